// File: rtl/mealy_seq_pkg.sv
// Shared types for the table-driven Mealy sequencer.
// Optional HALT behaviour is selected by SEQ_STOP_ON_ERR_EN.
package mealy_seq_pkg;

  localparam int NUM_STATES = 3;
  localparam int NUM_INPUTS = 3;
  localparam int OUT_W      = 4;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } fsm_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic [1:0]       ns;
    logic [OUT_W-1:0] out;
  } tbl_entry_t;

endpackage

// File: rtl/mealy_trans_table.sv
// 3x3 transition/output table: sync write, comb read, reset clear.
// Out-of-range reads return an all-zero entry.
module mealy_trans_table
  import mealy_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] wr_state,
  input  logic [1:0] wr_in,
  input  tbl_entry_t wr_data,
  input  logic [1:0] rd_state,
  input  logic [1:0] rd_in,
  output tbl_entry_t rd_data
);

  localparam logic [1:0] ST_LIM = 2'(NUM_STATES);
  localparam logic [1:0] IN_LIM = 2'(NUM_INPUTS);

  tbl_entry_t mem [NUM_STATES][NUM_INPUTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_STATES; s++)
        for (int i = 0; i < NUM_INPUTS; i++)
          mem[s][i] <= '0;
    end else if (we && wr_state < ST_LIM && wr_in < IN_LIM) begin
      mem[wr_state][wr_in] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_state < ST_LIM && rd_in < IN_LIM)
      rd_data = mem[rd_state][rd_in];
  end

endmodule

// File: rtl/mealy_table_sequencer.sv
// Steps a table-programmed 3-state Mealy FSM over a stimulus stream.
// Define SEQ_STOP_ON_ERR_EN to halt on the first output mismatch.
module mealy_table_sequencer
  import mealy_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_state,
  input  logic [1:0]       cfg_in,
  input  logic [1:0]       cfg_ns,
  input  logic [OUT_W-1:0] cfg_out,
  output logic             cfg_err,
  input  logic             start,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [1:0]       step_in,
  input  logic [OUT_W-1:0] step_exp,
  input  logic             step_last,
  output logic [1:0]       cur_state,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_LIM = 2'(NUM_STATES);
  localparam logic [1:0] IN_LIM = 2'(NUM_INPUTS);

  ctrl_state_t ctrl, ctrl_nxt;
  fsm_state_t  fsm;
  tbl_entry_t  entry;
  tbl_entry_t  wr_entry;

  logic cfg_ok, tbl_we, cfg_bad;
  logic start_go, accept, bad_in, miss;
  logic [OUT_W-1:0] step_out;
  logic [1:0]       step_ns;

  assign cfg_ok = cfg_state < ST_LIM && cfg_in < IN_LIM
               && cfg_ns < ST_LIM;
  assign tbl_we   = cfg_we && ctrl == IDLE && cfg_ok;
  assign cfg_bad  = cfg_we && !(ctrl == IDLE && cfg_ok);
  assign start_go = start && ctrl == IDLE;
  assign accept   = step_valid && step_ready;
  assign wr_entry = '{ns: cfg_ns, out: cfg_out};

  mealy_trans_table u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (tbl_we),
    .wr_state (cfg_state),
    .wr_in    (cfg_in),
    .wr_data  (wr_entry),
    .rd_state (fsm),
    .rd_in    (step_in),
    .rd_data  (entry)
  );

  // Illegal inputs force the machine home and always count as errors.
  assign bad_in   = step_in >= IN_LIM;
  assign step_out = bad_in ? '0 : entry.out;
  assign step_ns  = bad_in ? 2'd0 : entry.ns;
  assign miss     = bad_in || (entry.out != step_exp);

  assign step_ready = ctrl == RUN;
  assign busy       = ctrl != IDLE;
  assign cur_state  = fsm;

  always_ff @(posedge clk) begin
    if (reset) ctrl <= IDLE;
    else       ctrl <= ctrl_nxt;
  end

  always_comb begin
    ctrl_nxt = ctrl;
    unique case (ctrl)
      IDLE: if (start) ctrl_nxt = RUN;
      RUN: begin
`ifdef SEQ_STOP_ON_ERR_EN
        if (accept && miss)
          ctrl_nxt = HALT;
        else if (accept && step_last)
          ctrl_nxt = IDLE;
`else
        if (accept && step_last)
          ctrl_nxt = IDLE;
`endif
      end
`ifdef SEQ_STOP_ON_ERR_EN
      HALT: if (start) ctrl_nxt = IDLE;
`endif
      default: ctrl_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= ZERO;
      out       <= '0;
      out_valid <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= accept;
      mismatch  <= accept && miss;
`ifdef SEQ_STOP_ON_ERR_EN
      done      <= accept && (step_last || miss);
`else
      done      <= accept && step_last;
`endif
      if (start_go) begin
        fsm       <= ZERO;
        err_count <= '0;
      end else if (accept) begin
        fsm <= fsm_state_t'(step_ns);
        out <= step_out;
        if (miss && err_count != '1)
          err_count <= err_count + 1'b1;
      end
    end
  end

  // A bad write in the same cycle as start still leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset)        cfg_err <= 1'b0;
    else if (cfg_bad) cfg_err <= 1'b1;
    else if (start_go) cfg_err <= 1'b0;
  end

endmodule

// File: tb/tb_mealy_table_sequencer.sv
// Directed vector bench for mealy_table_sequencer.
// Covers both builds, with or without SEQ_STOP_ON_ERR_EN.
module tb_mealy_table_sequencer;
  import mealy_seq_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_we;
  logic [1:0]       cfg_state, cfg_in, cfg_ns;
  logic [OUT_W-1:0] cfg_out;
  logic             cfg_err;
  logic             start, step_valid, step_ready;
  logic [1:0]       step_in;
  logic [OUT_W-1:0] step_exp;
  logic             step_last;
  logic [1:0]       cur_state;
  logic [OUT_W-1:0] out;
  logic             out_valid, mismatch, busy, done;
  logic [CNT_W-1:0] err_count;

  always #5 clk = ~clk;

  mealy_table_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_state  (cfg_state),
    .cfg_in     (cfg_in),
    .cfg_ns     (cfg_ns),
    .cfg_out    (cfg_out),
    .cfg_err    (cfg_err),
    .start      (start),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_in    (step_in),
    .step_exp   (step_exp),
    .step_last  (step_last),
    .cur_state  (cur_state),
    .out        (out),
    .out_valid  (out_valid),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic             cerr;
    logic             rdy;
    logic [1:0]       cur;
    logic [OUT_W-1:0] o;
    logic             ov;
    logic             mm;
    logic [CNT_W-1:0] err;
    logic             bsy;
    logic             dn;
  } obs_t;

  typedef struct {
    string            name;
    logic             we;
    logic [1:0]       cs, ci, cns;
    logic [OUT_W-1:0] co;
    logic             st, sv;
    logic [1:0]       si;
    logic [OUT_W-1:0] se;
    logic             sl;
    obs_t             exp;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic obs_t ob(logic ce, logic r, int c, int o,
                              logic ov, logic mm, int e,
                              logic b, logic d);
    obs_t x;
    x.cerr = ce; x.rdy = r; x.cur = 2'(c); x.o = 4'(o);
    x.ov = ov; x.mm = mm; x.err = 8'(e); x.bsy = b; x.dn = d;
    return x;
  endfunction

  function automatic string fmt(obs_t x);
    return $sformatf(
      "cerr=%0d rdy=%0d cur=%0d out=%0d ov=%0d mm=%0d err=%0d busy=%0d done=%0d",
      x.cerr, x.rdy, x.cur, x.o, x.ov, x.mm, x.err, x.bsy, x.dn);
  endfunction

  function automatic obs_t sample();
    obs_t x;
    x.cerr = cfg_err; x.rdy = step_ready; x.cur = cur_state;
    x.o = out; x.ov = out_valid; x.mm = mismatch;
    x.err = err_count; x.bsy = busy; x.dn = done;
    return x;
  endfunction

  function automatic void cv(string nm, int s, int i, int ns, int o,
                             obs_t e);
    vq.push_back('{nm, 1'b1, 2'(s), 2'(i), 2'(ns), 4'(o),
                   1'b0, 1'b0, 2'd0, 4'd0, 1'b0, e});
  endfunction

  function automatic void sv(string nm, logic st, logic vld, int i,
                             int x, logic l, obs_t e);
    vq.push_back('{nm, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0,
                   st, vld, 2'(i), 4'(x), l, e});
  endfunction

  task automatic check(string nm, obs_t e);
    obs_t a;
    a = sample();
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got {%s} want {%s}", nm, fmt(a), fmt(e));
    end
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_state = 0; cfg_in = 0; cfg_ns = 0; cfg_out = 0;
    start = 0; step_valid = 0; step_in = 0; step_exp = 0;
    step_last = 0;
  endtask

  task automatic run_vec(vec_t v);
    cfg_we = v.we; cfg_state = v.cs; cfg_in = v.ci;
    cfg_ns = v.cns; cfg_out = v.co; start = v.st;
    step_valid = v.sv; step_in = v.si; step_exp = v.se;
    step_last = v.sl;
    @(posedge clk);
    #1;
    check(v.name, v.exp);
    idle_inputs();
  endtask

  task automatic run_all();
    foreach (vq[k]) run_vec(vq[k]);
    vq.delete();
  endtask

  function automatic void load_table();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 3; i++)
        cv("load", s, i, (s + 1) % 3, 4 * s + i,
           ob(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endfunction

  initial begin
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", ob(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 0;

    load_table();
    sv("start1", 1, 0, 0, 0, 0, ob(0, 1, 0, 0, 0, 0, 0, 1, 0));
    sv("t1s1", 0, 1, 0, 0, 0, ob(0, 1, 1, 0, 1, 0, 0, 1, 0));
    sv("t1s2", 0, 1, 1, 5, 0, ob(0, 1, 2, 5, 1, 0, 0, 1, 0));
    sv("t1s3", 0, 1, 2, 10, 1, ob(0, 0, 0, 10, 1, 0, 0, 0, 1));
    sv("t1idle", 0, 0, 0, 0, 0, ob(0, 0, 0, 10, 0, 0, 0, 0, 0));
    sv("idle_step", 0, 1, 0, 0, 0, ob(0, 0, 0, 10, 0, 0, 0, 0, 0));
    cv("bad_ns", 0, 0, 3, 7, ob(1, 0, 0, 10, 0, 0, 0, 0, 0));
    sv("start2", 1, 0, 0, 0, 0, ob(0, 1, 0, 10, 0, 0, 0, 1, 0));
    cv("run_we", 0, 0, 2, 15, ob(1, 1, 0, 10, 0, 0, 0, 1, 0));
    sv("run_start", 1, 0, 0, 0, 0, ob(1, 1, 0, 10, 0, 0, 0, 1, 0));
    sv("t4s1", 0, 1, 0, 0, 1, ob(1, 0, 1, 0, 1, 0, 0, 0, 1));
    sv("start3", 1, 0, 0, 0, 0, ob(0, 1, 0, 0, 0, 0, 0, 1, 0));
    sv("t4s2", 0, 1, 0, 0, 1, ob(0, 0, 1, 0, 1, 0, 0, 0, 1));
    vq.push_back('{"we_start", 1'b1, 2'd0, 2'd0, 2'd2, 4'd9,
                   1'b1, 1'b0, 2'd0, 4'd0, 1'b0,
                   ob(0, 1, 0, 0, 0, 0, 0, 1, 0)});
    sv("sim_s1", 0, 1, 0, 9, 1, ob(0, 0, 2, 9, 1, 0, 0, 0, 1));
    cv("restore", 0, 0, 1, 0, ob(0, 0, 2, 9, 0, 0, 0, 0, 0));
    run_all();

`ifndef SEQ_STOP_ON_ERR_EN
    sv("start4", 1, 0, 0, 0, 0, ob(0, 1, 0, 9, 0, 0, 0, 1, 0));
    sv("t2s1", 0, 1, 0, 0, 0, ob(0, 1, 1, 0, 1, 0, 0, 1, 0));
    sv("t2s2", 0, 1, 1, 15, 0, ob(0, 1, 2, 5, 1, 1, 1, 1, 0));
    sv("t2s3", 0, 1, 2, 10, 1, ob(0, 0, 0, 10, 1, 0, 1, 0, 1));
    sv("start5", 1, 0, 0, 0, 0, ob(0, 1, 0, 10, 0, 0, 0, 1, 0));
    sv("t5s1", 0, 1, 0, 0, 0, ob(0, 1, 1, 0, 1, 0, 0, 1, 0));
    sv("t5s2", 0, 1, 1, 5, 0, ob(0, 1, 2, 5, 1, 0, 0, 1, 0));
    sv("t5bad", 0, 1, 3, 0, 0, ob(0, 1, 0, 0, 1, 1, 1, 1, 0));
    sv("t5s4", 0, 1, 0, 0, 1, ob(0, 0, 1, 0, 1, 0, 1, 0, 1));
    cv("bad_st", 3, 0, 0, 0, ob(1, 0, 1, 0, 0, 0, 1, 0, 0));
    sv("start6", 1, 0, 0, 0, 0, ob(0, 1, 0, 0, 0, 0, 0, 1, 0));
    run_all();

    // Input 0 walks 0->1->2->0 with outputs 0,4,8; never 15.
    for (int k = 1; k <= 300; k++) begin
      step_valid = 1; step_in = 0; step_exp = 4'hF;
      step_last = (k == 300);
      @(posedge clk);
      #1;
      idle_inputs();
      if (k == 100 || k == 254 || k == 255 || k == 300) begin
        n_chk++;
        if (err_count !== 8'(k > 255 ? 255 : k) || mismatch !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_%0d: got err=%0d mm=%0d want err=%0d mm=1",
                   k, err_count, mismatch, (k > 255 ? 255 : k));
        end
      end
    end
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || cur_state !== 2'(300 % 3)) begin
      n_fail++;
      $display("FAIL sat_end: got done=%0d busy=%0d cur=%0d want 1 0 0",
               done, busy, cur_state);
    end
`endif

    // Mid-run reset must also clear the table.
    start = 1;
    @(posedge clk);
    #1;
    idle_inputs();
    sv("mr_s1", 0, 1, 0, 0, 0, ob(0, 1, 1, 0, 1, 0, 0, 1, 0));
    run_all();
    reset = 1;
    @(posedge clk);
    #1;
    check("mr_reset", ob(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 0;
    sv("mr_start", 1, 0, 0, 0, 0, ob(0, 1, 0, 0, 0, 0, 0, 1, 0));
    sv("mr_s2", 0, 1, 0, 0, 0, ob(0, 1, 0, 0, 1, 0, 0, 1, 0));
    sv("mr_s3", 0, 1, 1, 0, 1, ob(0, 0, 0, 0, 1, 0, 0, 0, 1));
    run_all();

`ifdef SEQ_STOP_ON_ERR_EN
    load_table();
    sv("h_start", 1, 0, 0, 0, 0, ob(0, 1, 0, 0, 0, 0, 0, 1, 0));
    sv("h_s1", 0, 1, 0, 0, 0, ob(0, 1, 1, 0, 1, 0, 0, 1, 0));
    sv("h_s2", 0, 1, 1, 15, 0, ob(0, 0, 2, 5, 1, 1, 1, 1, 1));
    sv("h_hold", 0, 1, 1, 15, 0, ob(0, 0, 2, 5, 0, 0, 1, 1, 0));
    sv("h_exit", 1, 0, 0, 0, 0, ob(0, 0, 2, 5, 0, 0, 1, 0, 0));
    sv("h_rerun", 1, 0, 0, 0, 0, ob(0, 1, 0, 5, 0, 0, 0, 1, 0));
    sv("h_last", 0, 1, 2, 2, 1, ob(0, 0, 1, 2, 1, 0, 0, 0, 1));
    run_all();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mealy_table_sequencer.md
Name: mealy_table_sequencer

Overview:
Programmable controller for our 3-state Mealy machines with 2-bit input and 4-bit output. It holds the transition/output table (loaded through a config port) and steps the machine through a handshaked stimulus stream. Each step's output is checked against an expected value, and mismatches are counted. It sits between the stimulus source and the per-FSM checkers, replacing hand-driven current-state and next-state wiring.

Parameters:
- NUM_STATES, 3, legal state codes 0..NUM_STATES-1 (ZERO=0, ONE=1, TWO=2); codes >= NUM_STATES are illegal.
- NUM_INPUTS, 3, legal input codes 0..NUM_INPUTS-1; codes >= NUM_INPUTS are illegal.
- OUT_W, 4, width of the Mealy output.
- CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_state  in  2  table row (current state)
- cfg_in  in  2  table column (input)
- cfg_ns  in  2  next state for the entry
- cfg_out  in  OUT_W  Mealy output for the entry
- cfg_err  out  1  sticky config error
- start  in  1  begin a run (honoured in IDLE only)
- step_valid  in  1  stimulus valid
- step_ready  out  1  stimulus accepted this cycle when high together with valid
- step_in  in  2  FSM input for this step
- step_exp  in  OUT_W  expected output for this step
- step_last  in  1  final step of the run
- cur_state  out  2  current FSM state
- out  out  OUT_W  Mealy output of the last accepted step
- out_valid  out  1  one-cycle pulse per accepted step
- mismatch  out  1  one-cycle pulse, aligned with out_valid
- err_count  out  CNT_W  mismatches this run, saturating at all-ones
- busy  out  1  high in RUN (and HALT, if compiled in)
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset values:
  - All outputs 0.
  - Controller state IDLE.
  - All 9 table entries {ns=0, out=0}.
- Controller states:
  - IDLE: step_ready=0. On cfg_we, write table[cfg_state][cfg_in] <= {cfg_ns, cfg_out}. On start: cur_state<=0, err_count<=0, cfg_err<=0, go to RUN.
  - RUN: step_ready=1. On step_valid&step_ready (accept) at cycle N, the following is registered and visible at N+1:
    - e = table[cur_state][step_in]; out<=e.out; cur_state<=e.ns; out_valid<=1.
    - mismatch<=(e.out!=step_exp); err_count increments on mismatch, holding at 2^CNT_W-1.
  - Accept with step_last=1: step is processed normally, done pulses at N+1, and the controller goes to IDLE at N+1. That step's mismatch is counted before done.
  - DONE is not a separate state; cur_state, out and err_count hold in IDLE until the next start.
- Illegal step_in (>= NUM_INPUTS):
  - Step is still accepted; out<=0 and cur_state<=0.
  - mismatch<=1 unconditionally; counted.
- Config rules:
  - cfg_we with cfg_state, cfg_in or cfg_ns illegal: write dropped, cfg_err<=1.
  - cfg_we outside IDLE: write dropped, cfg_err<=1.
  - cfg_err is sticky; cleared only by reset or by an accepted start.
- Simultaneous events:
  - start and cfg_we in the same IDLE cycle: the write takes effect and the run starts. The first step can be accepted no earlier than the next cycle, so it sees the new entry.
  - start outside IDLE: ignored.
  - step_valid in IDLE: not accepted, since step_ready=0.
- Reset mid-run: immediate return to reset values, including table clear.
- out/out_valid/mismatch are registered; there is no combinational path from step_* to the outputs.

Optional Feature:
- Macro: SEQ_STOP_ON_ERR_EN.
- When defined:
  - Adds a HALT state. On the first mismatch in RUN, go to HALT at N+1 (the mismatch is reported and counted).
  - In HALT: step_ready=0 and busy=1. done pulses on HALT entry.
  - start in HALT returns to IDLE, with no new run; a further start is required.
  - A mismatch on a step_last step goes to HALT, not IDLE.
- When undefined: no HALT state; runs continue through mismatches.

Decomposition:
- Package mealy_seq_pkg:
  - fsm_state_t enum ZERO/ONE/TWO (2-bit).
  - ctrl_state_t enum IDLE/RUN/HALT.
  - tbl_entry_t struct {ns, out}.
  - NUM_STATES/NUM_INPUTS localparams.
- Sub-module mealy_trans_table:
  - 3x3 register array of tbl_entry_t.
  - Synchronous write port, combinational read port, reset clear.

Test Plan:
1. Load a table where every entry for state s, input i is {ns=(s+1)%3, out=4*s+i}. start, then steps in=0,1,2 with correct exp, last on step 3 → out=0,5,10; cur_state 1,2,0; err_count=0; done at cycle after step 3.
2. Same table, step 2 with exp=4'hF → mismatch pulse only on step 2, err_count=1, run completes.
3. 300 mismatching steps → err_count saturates at 255.
4. cfg_we with cfg_ns=3, and cfg_we during RUN → no table change, cfg_err=1; next start clears it.
5. step_in=3 in state TWO → out=0, cur_state=0, mismatch=1.
6. With SEQ_STOP_ON_ERR_EN: mismatch on step 2 of 5 → step_ready low from the next cycle, busy=1, done pulse; start → IDLE, busy=0.
